jtag_tap_multi_dr: RTL and testbench

Parametrised JTAG TAP for the debug transport module (debug spec 0.13) with a configurable number of user data registers. Besides the standard IDCODE, BYPASS, DTMCSR and DMIACCESS paths, it adds `NumUserDr` user DR channels, a `dmihardreset` pulse and a configurable DMI address width. It sits between the JTAG pads and the DMI/DTM logic, and also feeds user DR consumers such as trace and fuse-override registers.

---
 rtl/jtag_tap_pkg.sv | 52 +++++
 rtl/jtag_tap_fsm.sv | 87 ++++++++
 rtl/jtag_tap_multi_dr.sv | 249 ++++++++++++++++++++++++
 tb/tb_jtag_tap_multi_dr.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/jtag_tap_pkg.sv
// ============================================================================
//  Module      : jtag_tap_pkg
//  Description : Shared types and constants for the multi-DR JTAG TAP:
//                TAP state encoding, DTMCS register layout and IR codes.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package jtag_tap_pkg;

    // IEEE 1149.1 TAP controller states
    typedef enum logic [3:0] {
        TestLogicReset = 4'd0,
        RunTestIdle    = 4'd1,
        SelectDrScan   = 4'd2,
        CaptureDr      = 4'd3,
        ShiftDr        = 4'd4,
        Exit1Dr        = 4'd5,
        PauseDr        = 4'd6,
        Exit2Dr        = 4'd7,
        UpdateDr       = 4'd8,
        SelectIrScan   = 4'd9,
        CaptureIr      = 4'd10,
        ShiftIr        = 4'd11,
        Exit1Ir        = 4'd12,
        PauseIr        = 4'd13,
        Exit2Ir        = 4'd14,
        UpdateIr       = 4'd15
    } tap_state_e;

    // DTM control and status register, debug spec 0.13 layout
    typedef struct packed {
        logic [13:0] zero1;
        logic        dmihardreset;
        logic        dmireset;
        logic        zero0;
        logic [2:0]  idle;
        logic [1:0]  dmistat;
        logic [5:0]  abits;
        logic [3:0]  version;
    } dtmcs_t;

    localparam int unsigned c_IR_BYPASS0   = 32'h00;
    localparam int unsigned c_IR_IDCODE    = 32'h01;
    localparam int unsigned c_IR_DTMCSR    = 32'h10;
    localparam int unsigned c_IR_DMIACCESS = 32'h11;

    localparam logic [3:0] c_DTMCS_VERSION = 4'd1;

endpackage

`default_nettype wire

// File: rtl/jtag_tap_fsm.sv
// ============================================================================
//  Module      : jtag_tap_fsm
//  Description : IEEE 1149.1 TAP controller state machine with state decodes.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module jtag_tap_fsm (
    input  logic tck_i,
    input  logic trst_ni,
    input  logic tms_i,
    output logic test_logic_reset_o,
    output logic capture_dr_o,
    output logic shift_dr_o,
    output logic update_dr_o,
    output logic capture_ir_o,
    output logic shift_ir_o,
    output logic update_ir_o
);
    import jtag_tap_pkg::*;

    tap_state_e state_q, state_d;

    // State register, asynchronously reset to TestLogicReset
    always_ff @(posedge tck_i or negedge trst_ni) begin
        if (!trst_ni) begin
            state_q <= TestLogicReset;
        end else begin
            state_q <= state_d;
        end
    end

    // Standard TMS-driven transitions plus combinational state decodes
    always_comb begin
        state_d            = state_q;
        test_logic_reset_o = 1'b0;
        capture_dr_o       = 1'b0;
        shift_dr_o         = 1'b0;
        update_dr_o        = 1'b0;
        capture_ir_o       = 1'b0;
        shift_ir_o         = 1'b0;
        update_ir_o        = 1'b0;
        case (state_q)
            TestLogicReset: begin
                test_logic_reset_o = 1'b1;
                state_d = tms_i ? TestLogicReset : RunTestIdle;
            end
            RunTestIdle:  state_d = tms_i ? SelectDrScan : RunTestIdle;
            SelectDrScan: state_d = tms_i ? SelectIrScan : CaptureDr;
            CaptureDr: begin
                capture_dr_o = 1'b1;
                state_d = tms_i ? Exit1Dr : ShiftDr;
            end
            ShiftDr: begin
                shift_dr_o = 1'b1;
                state_d = tms_i ? Exit1Dr : ShiftDr;
            end
            Exit1Dr:      state_d = tms_i ? UpdateDr : PauseDr;
            PauseDr:      state_d = tms_i ? Exit2Dr : PauseDr;
            Exit2Dr:      state_d = tms_i ? UpdateDr : ShiftDr;
            UpdateDr: begin
                update_dr_o = 1'b1;
                state_d = tms_i ? SelectDrScan : RunTestIdle;
            end
            SelectIrScan: state_d = tms_i ? TestLogicReset : CaptureIr;
            CaptureIr: begin
                capture_ir_o = 1'b1;
                state_d = tms_i ? Exit1Ir : ShiftIr;
            end
            ShiftIr: begin
                shift_ir_o = 1'b1;
                state_d = tms_i ? Exit1Ir : ShiftIr;
            end
            Exit1Ir:      state_d = tms_i ? UpdateIr : PauseIr;
            PauseIr:      state_d = tms_i ? Exit2Ir : PauseIr;
            Exit2Ir:      state_d = tms_i ? UpdateIr : ShiftIr;
            UpdateIr: begin
                update_ir_o = 1'b1;
                state_d = tms_i ? SelectDrScan : RunTestIdle;
            end
            default:      state_d = TestLogicReset;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/jtag_tap_multi_dr.sv
// ============================================================================
//  Module      : jtag_tap_multi_dr
//  Description : JTAG TAP for the debug transport module with IDCODE, BYPASS,
//                DTMCS, DMIACCESS and NumUserDr user data register channels.
//                Optional macro JTAG_TAP_TMS_RESET_EN adds a TMS-history
//                synchronous reset (five consecutive TMS=1 samples).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module jtag_tap_multi_dr #(
    parameter int unsigned IrLength    = 5,
    parameter logic [31:0] IdcodeValue = 32'h00000001,
    parameter int unsigned NumUserDr   = 2,
    parameter int unsigned UserDrWidth = 32,
    parameter int unsigned UserIrBase  = 'h12,
    parameter int unsigned DmiAbits    = 7,
    parameter int unsigned IdleHint    = 1
) (
    input  logic                             tck_i,
    input  logic                             trst_ni,
    input  logic                             tms_i,
    input  logic                             td_i,
    output logic                             td_o,
    output logic                             tdo_oe_o,
    input  logic                             testmode_i,
    output logic                             test_logic_reset_o,
    output logic                             capture_dr_o,
    output logic                             shift_dr_o,
    output logic                             update_dr_o,
    output logic                             dmi_access_o,
    output logic                             dtmcs_select_o,
    output logic                             dmi_reset_o,
    output logic                             dmi_hardreset_o,
    input  logic [1:0]                       dmi_error_i,
    output logic                             dmi_tdi_o,
    input  logic                             dmi_tdo_i,
    output logic [NumUserDr-1:0]             user_select_o,
    input  logic [NumUserDr*UserDrWidth-1:0] user_capture_i,
    output logic [NumUserDr-1:0]             user_update_o,
    output logic [UserDrWidth-1:0]           user_data_o
);
    import jtag_tap_pkg::*;

    logic w_tlr, w_capture_ir, w_shift_ir, w_update_ir;
    logic w_capture_dr, w_shift_dr, w_update_dr;

    logic [IrLength-1:0]    ir_q, ir_d, ir_shift_q, ir_shift_d;
    logic                   bypass_q, bypass_d;
    logic [31:0]            idcode_q, idcode_d;
    dtmcs_t                 dtmcs_q, dtmcs_d;
    logic [UserDrWidth-1:0] user_q, user_d, user_data_q, user_data_d;
    logic [NumUserDr-1:0]   user_update_q, user_update_d;
    logic                   dmi_reset_q, dmi_reset_d, dmi_hardreset_q, dmi_hardreset_d;
    logic                   td_q, tdo_oe_q;

    logic [NumUserDr-1:0]   w_user_sel;
    logic                   w_sel_idcode, w_sel_dtmcs, w_sel_dmi, w_sel_user, w_sel_bypass;
    logic [UserDrWidth-1:0] w_user_capture;
    logic [IrLength:0]      w_ir_cat;
    logic [UserDrWidth:0]   w_user_cat;
    logic                   w_tdo, w_tck_tdo;

    jtag_tap_fsm u_fsm (
        .tck_i              (tck_i),
        .trst_ni            (trst_ni),
        .tms_i              (tms_i),
        .test_logic_reset_o (w_tlr),
        .capture_dr_o       (w_capture_dr),
        .shift_dr_o         (w_shift_dr),
        .update_dr_o        (w_update_dr),
        .capture_ir_o       (w_capture_ir),
        .shift_ir_o         (w_shift_ir),
        .update_ir_o        (w_update_ir)
    );

`ifdef JTAG_TAP_TMS_RESET_EN
    logic [3:0] tms_hist_q;
    logic       w_sync_rst;

    // Four-deep TMS history; together with the live TMS it detects five ones
    always_ff @(posedge tck_i or negedge trst_ni) begin
        if (!trst_ni) begin
            tms_hist_q <= '0;
        end else begin
            tms_hist_q <= {tms_hist_q[2:0], tms_i};
        end
    end
    assign w_sync_rst = &{tms_hist_q, tms_i};
`endif

    for (genvar gi = 0; gi < NumUserDr; gi++) begin : g_user_sel
        assign w_user_sel[gi] = (ir_q == IrLength'(UserIrBase + gi));
    end

    // IR decode; anything not claimed by a register falls back to BYPASS
    always_comb begin
        w_sel_idcode = (ir_q == IrLength'(c_IR_IDCODE));
        w_sel_dtmcs  = (ir_q == IrLength'(c_IR_DTMCSR));
        w_sel_dmi    = (ir_q == IrLength'(c_IR_DMIACCESS));
        w_sel_user   = |w_user_sel;
        w_sel_bypass = ~(w_sel_idcode | w_sel_dtmcs | w_sel_dmi | w_sel_user);
    end

    // Capture value of the currently selected user channel
    always_comb begin
        w_user_capture = '0;
        for (int i = 0; i < NumUserDr; i++) begin
            if (w_user_sel[i]) begin
                w_user_capture = w_user_capture | user_capture_i[i*UserDrWidth +: UserDrWidth];
            end
        end
    end

    // Shift-in concatenations keep single-bit widths legal
    assign w_ir_cat   = {td_i, ir_shift_q};
    assign w_user_cat = {td_i, user_q};

    // Next state of IR, DR chains and update pulses
    always_comb begin
        ir_d            = ir_q;
        ir_shift_d      = ir_shift_q;
        bypass_d        = bypass_q;
        idcode_d        = idcode_q;
        dtmcs_d         = dtmcs_q;
        user_d          = user_q;
        user_data_d     = user_data_q;
        user_update_d   = '0;
        dmi_reset_d     = 1'b0;
        dmi_hardreset_d = 1'b0;

        if (w_tlr) begin
            ir_d       = IrLength'(c_IR_IDCODE);
            ir_shift_d = '0;
        end
        if (w_capture_ir) ir_shift_d = IrLength'(2'b01);
        if (w_shift_ir)   ir_shift_d = w_ir_cat[IrLength:1];
        if (w_update_ir)  ir_d       = ir_shift_q;

        if (w_capture_dr) begin
            if (w_sel_bypass) bypass_d = 1'b0;
            if (w_sel_idcode) idcode_d = IdcodeValue;
            if (w_sel_dtmcs) begin
                dtmcs_d         = '0;
                dtmcs_d.idle    = 3'(IdleHint);
                dtmcs_d.dmistat = dmi_error_i;
                dtmcs_d.abits   = 6'(DmiAbits);
                dtmcs_d.version = c_DTMCS_VERSION;
            end
            if (w_sel_user)   user_d = w_user_capture;
        end
        if (w_shift_dr) begin
            if (w_sel_bypass) bypass_d = td_i;
            if (w_sel_idcode) idcode_d = {td_i, idcode_q[31:1]};
            if (w_sel_dtmcs)  dtmcs_d  = dtmcs_t'({td_i, dtmcs_q[31:1]});
            if (w_sel_user)   user_d   = w_user_cat[UserDrWidth:1];
        end
        if (w_update_dr) begin
            dmi_reset_d     = w_sel_dtmcs & dtmcs_q.dmireset;
            dmi_hardreset_d = w_sel_dtmcs & dtmcs_q.dmihardreset;
            user_update_d   = w_user_sel;
            if (w_sel_user) user_data_d = user_q;
        end

`ifdef JTAG_TAP_TMS_RESET_EN
        if (w_sync_rst) begin
            ir_d            = IrLength'(c_IR_IDCODE);
            ir_shift_d      = '0;
            bypass_d        = 1'b0;
            idcode_d        = '0;
            dtmcs_d         = '0;
            user_d          = '0;
            user_data_d     = '0;
            user_update_d   = '0;
            dmi_reset_d     = 1'b0;
            dmi_hardreset_d = 1'b0;
        end
`endif
    end

    // Rising-edge registers for IR, DR chains and update outputs
    always_ff @(posedge tck_i or negedge trst_ni) begin
        if (!trst_ni) begin
            ir_q            <= IrLength'(c_IR_IDCODE);
            ir_shift_q      <= '0;
            bypass_q        <= 1'b0;
            idcode_q        <= '0;
            dtmcs_q         <= '0;
            user_q          <= '0;
            user_data_q     <= '0;
            user_update_q   <= '0;
            dmi_reset_q     <= 1'b0;
            dmi_hardreset_q <= 1'b0;
        end else begin
            ir_q            <= ir_d;
            ir_shift_q      <= ir_shift_d;
            bypass_q        <= bypass_d;
            idcode_q        <= idcode_d;
            dtmcs_q         <= dtmcs_d;
            user_q          <= user_d;
            user_data_q     <= user_data_d;
            user_update_q   <= user_update_d;
            dmi_reset_q     <= dmi_reset_d;
            dmi_hardreset_q <= dmi_hardreset_d;
        end
    end

    // TDO source: IR chain while shifting IR, otherwise the selected DR
    always_comb begin
        w_tdo = bypass_q;
        if (w_shift_ir)        w_tdo = ir_shift_q[0];
        else if (w_sel_dmi)    w_tdo = dmi_tdo_i;
        else if (w_sel_idcode) w_tdo = idcode_q[0];
        else if (w_sel_dtmcs)  w_tdo = dtmcs_q.version[0];
        else if (w_sel_user)   w_tdo = user_q[0];
    end

    // In DFT mode the TDO flops run on the true clock instead of the inverted one
    assign w_tck_tdo = testmode_i ? tck_i : ~tck_i;

    // TDO and its enable launch half a cycle after the state change
    always_ff @(posedge w_tck_tdo or negedge trst_ni) begin
        if (!trst_ni) begin
            td_q     <= 1'b0;
            tdo_oe_q <= 1'b0;
        end else begin
            td_q     <= w_tdo;
            tdo_oe_q <= w_shift_ir | w_shift_dr;
        end
    end

    assign td_o               = td_q;
    assign tdo_oe_o           = tdo_oe_q;
    assign test_logic_reset_o = w_tlr;
    assign capture_dr_o       = w_capture_dr;
    assign shift_dr_o         = w_shift_dr;
    assign update_dr_o        = w_update_dr;
    assign dmi_access_o       = w_sel_dmi;
    assign dtmcs_select_o     = w_sel_dtmcs;
    assign dmi_reset_o        = dmi_reset_q;
    assign dmi_hardreset_o    = dmi_hardreset_q;
    assign dmi_tdi_o          = td_i;
    assign user_select_o      = w_user_sel;
    assign user_update_o      = user_update_q;
    assign user_data_o        = user_data_q;

endmodule

`default_nettype wire

// File: tb/tb_jtag_tap_multi_dr.sv
// ============================================================================
//  Module      : tb_jtag_tap_multi_dr
//  Description : Self-checking bench for jtag_tap_multi_dr (3 user channels).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_jtag_tap_multi_dr;

    localparam int NU = 3;
    localparam int UW = 32;

    logic          tck = 1'b0, trst_n = 1'b0, tms = 1'b1, tdi = 1'b0;
    logic          testmode = 1'b0, dmi_tdo = 1'b1;
    logic [1:0]    dmi_err = 2'b10;
    logic [NU*UW-1:0] user_cap = {32'hDEADBEEF, 32'hA5A50F0F, 32'h11112222};

    logic          td_o, tdo_oe, tlr, cap_dr, sh_dr, upd_dr, dmi_acc, dtmcs_sel;
    logic          dmi_rst, dmi_hrst, dmi_tdi;
    logic [NU-1:0] user_sel, user_upd;
    logic [UW-1:0] user_data;

    jtag_tap_multi_dr #(.NumUserDr(NU), .UserDrWidth(UW)) dut (
        .tck_i(tck), .trst_ni(trst_n), .tms_i(tms), .td_i(tdi), .td_o(td_o),
        .tdo_oe_o(tdo_oe), .testmode_i(testmode), .test_logic_reset_o(tlr),
        .capture_dr_o(cap_dr), .shift_dr_o(sh_dr), .update_dr_o(upd_dr),
        .dmi_access_o(dmi_acc), .dtmcs_select_o(dtmcs_sel), .dmi_reset_o(dmi_rst),
        .dmi_hardreset_o(dmi_hrst), .dmi_error_i(dmi_err), .dmi_tdi_o(dmi_tdi),
        .dmi_tdo_i(dmi_tdo), .user_select_o(user_sel), .user_capture_i(user_cap),
        .user_update_o(user_upd), .user_data_o(user_data)
    );

    always #5 tck = ~tck;

    int n_cmp = 0, n_bad = 0;
    logic [31:0] exp_user_data = '0;

    typedef struct {
        int          ir;
        int          len;
        logic [63:0] din;
        int          pause;
        logic [63:0] exp_out;
        logic [2:0]  exp_uu;
        logic        exp_r;
        logic        exp_h;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One TCK cycle: drive TMS/TDI, report TDO as it stood before the edge
    task automatic tick(input logic m, input logic d, output logic o);
        tms = m;
        tdi = d;
        o   = td_o;
        @(posedge tck);
        @(negedge tck);
        #1;
    endtask

    // Reference: a DR is a FIFO of its bits; each shift pops TDO and pushes TDI
    function automatic logic [63:0] model_scan(input int ir, input int n,
                                               input logic [63:0] din, output logic [63:0] fin);
        bit q[$];
        logic [63:0] cap, out;
        int len;
        out = '0;
        fin = '0;
        if (ir == 'h01) begin
            len = 32; cap = 64'h1;
        end else if (ir == 'h10) begin
            len = 32;
            cap = 64'((1 << 12) | (32'(dmi_err) << 10) | (7 << 4) | 1);
        end else if (ir >= 'h12 && ir < 'h12 + NU) begin
            len = UW; cap = 64'(user_cap[(ir-'h12)*UW +: UW]);
        end else begin
            len = 1; cap = '0;
        end
        for (int k = 0; k < len; k++) q.push_back(cap[k]);
        for (int i = 0; i < n; i++) begin
            bit b;
            b = q.pop_front();
            out[i] = (ir == 'h11) ? dmi_tdo : b;
            q.push_back(din[i]);
        end
        for (int k = 0; k < len; k++) fin[k] = q[k];
        return out;
    endfunction

    task automatic scan_ir(input logic [4:0] v, output logic [4:0] dout);
        logic o;
        tick(1, 0, o); tick(1, 0, o); tick(0, 0, o); tick(0, 0, o);
        for (int i = 0; i < 5; i++) begin
            tick(i == 4, v[i], o);
            dout[i] = o;
        end
        tick(1, 0, o); tick(0, 0, o);
    endtask

    // DR scan from RunTestIdle; ends in RunTestIdle, or SelectDrScan when to_sel
    task automatic scan_dr(input int n, input logic [63:0] din, input int pause_at,
                           input bit to_sel, output logic [63:0] dout, output bit ok);
        logic o;
        dout = '0;
        ok   = 1'b1;
        tick(1, 0, o); tick(0, 0, o);
        if (cap_dr !== 1'b1) ok = 1'b0;
        tick(0, 0, o);
        for (int i = 0; i < n; i++) begin
            bit last;
            last = (i == n - 1);
            if (tdo_oe !== 1'b1 || sh_dr !== 1'b1) ok = 1'b0;
            tick(last || i == pause_at, din[i], o);
            dout[i] = o;
            if (!last && i == pause_at) begin
                tick(0, 0, o);
                repeat (10) tick(0, 0, o);
                tick(1, 0, o); tick(0, 0, o);
            end
        end
        tick(1, 0, o);
        if (upd_dr !== 1'b1) ok = 1'b0;
        tick(to_sel, 0, o);
    endtask

    task automatic run_vec(input int ir, input int n, input logic [63:0] din, input int pause,
                           input bit has_exp, input logic [63:0] e_out, input logic [2:0] e_uu,
                           input logic e_r, input logic e_h);
        logic [4:0]  irout;
        logic [63:0] dout, fin, mout, mask;
        logic [2:0]  e_sel;
        bit ok;
        logic o;
        scan_ir(5'(ir), irout);
        chk("ir_capture", 64'(irout), 64'h1);
        e_sel = (ir >= 'h12 && ir < 'h12 + NU) ? 3'(1 << (ir - 'h12)) : 3'b000;
        chk("ir_decode", {user_sel, dtmcs_sel, dmi_acc}, {e_sel, ir == 'h10, ir == 'h11});
        mout = model_scan(ir, n, din, fin);
        if (!has_exp) begin
            e_out = mout;
            e_uu  = e_sel;
            e_r   = (ir == 'h10) && fin[16];
            e_h   = (ir == 'h10) && fin[17];
        end
        scan_dr(n, din, pause, 1'b0, dout, ok);
        mask = (n >= 64) ? '1 : ((64'd1 << n) - 1);
        chk("dr_out", dout & mask, e_out & mask);
        chk("scan_decodes_oe", 64'(ok), 64'h1);
        chk("tdo_oe_idle", 64'(tdo_oe), 64'h0);
        chk("update_pulses", {user_upd, dmi_rst, dmi_hrst}, {e_uu, e_r, e_h});
        if (e_sel != 0) exp_user_data = fin[31:0];
        tick(0, 0, o);
        chk("pulse_end", {user_upd, dmi_rst, dmi_hrst}, 64'h0);
        chk("user_data", 64'(user_data), 64'(exp_user_data));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: no finish by time %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[11];
        logic o;
        logic [4:0]  irout;
        logic [63:0] dout, fin, mout, din;
        bit ok;

        vecs[0]  = '{'h01, 32, 64'h0,            -1, 64'h1,            3'b000, 1'b0, 1'b0};
        vecs[1]  = '{'h10, 32, 64'h0,            -1, 64'h1871,         3'b000, 1'b0, 1'b0};
        vecs[2]  = '{'h10, 32, 64'h30000,        -1, 64'h1871,         3'b000, 1'b1, 1'b1};
        vecs[3]  = '{'h13, 32, 64'h12345678,     -1, 64'hA5A50F0F,     3'b010, 1'b0, 1'b0};
        vecs[4]  = '{'h13, 32, 64'h12345678,     13, 64'hA5A50F0F,     3'b010, 1'b0, 1'b0};
        vecs[5]  = '{'h0A,  8, 64'hB5,           -1, 64'h6A,           3'b000, 1'b0, 1'b0};
        vecs[6]  = '{'h1F,  4, 64'hF,            -1, 64'hE,            3'b000, 1'b0, 1'b0};
        vecs[7]  = '{'h11,  8, 64'h3C,           -1, 64'hFF,           3'b000, 1'b0, 1'b0};
        vecs[8]  = '{'h10, 32, 64'h10000,         5, 64'h1871,         3'b000, 1'b1, 1'b0};
        vecs[9]  = '{'h14, 32, 64'hCAFEF00D,     -1, 64'hDEADBEEF,     3'b100, 1'b0, 1'b0};
        vecs[10] = '{'h12, 40, 64'hAB12345678,   -1, 64'h7811112222,   3'b001, 1'b0, 1'b0};

        // Reset state while trst is asserted
        @(negedge tck); #1;
        chk("rst_tlr", 64'(tlr), 64'h1);
        chk("rst_decodes", {cap_dr, sh_dr, upd_dr, dmi_acc, dtmcs_sel, user_sel}, 64'h0);
        chk("rst_tdo", {td_o, tdo_oe}, 64'h0);
        chk("rst_pulses", {user_upd, dmi_rst, dmi_hrst}, 64'h0);
        chk("rst_user_data", 64'(user_data), 64'h0);

        trst_n = 1'b1;
        repeat (5) tick(1, 0, o);
        chk("tms_tlr", 64'(tlr), 64'h1);
        tick(0, 0, o);
        chk("rti_not_tlr", 64'(tlr), 64'h0);

        // IDCODE is the reset IR, so a bare DR scan returns it
        scan_dr(32, 64'h0, -1, 1'b0, dout, ok);
        chk("idcode_after_reset", dout & 64'hFFFFFFFF, 64'h1);
        chk("idcode_scan_oe", 64'(ok), 64'h1);

        for (int i = 0; i < 11; i++) begin
            run_vec(vecs[i].ir, vecs[i].len, vecs[i].din, vecs[i].pause, 1'b1,
                    vecs[i].exp_out, vecs[i].exp_uu, vecs[i].exp_r, vecs[i].exp_h);
        end

        for (int i = 0; i < 16; i++) begin
            int ir, n, p;
            ir = $urandom_range(0, 31);
            n  = $urandom_range(1, 40);
            p  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, n - 1) : -1;
            run_vec(ir, n, {$urandom, $urandom}, p, 1'b0, 64'h0, 3'b000, 1'b0, 1'b0);
        end

        // Five TMS=1 from ShiftDr of a user channel lands in TestLogicReset
        scan_ir(5'h13, irout);
        chk("tmsrst_ir_capture", 64'(irout), 64'h1);
        din  = {32'h0, $urandom};
        mout = model_scan('h13, 10, din, fin);
        scan_dr(10, din, -1, 1'b1, dout, ok);
        chk("tmsrst_out", dout & 64'h3FF, mout & 64'h3FF);
        tick(1, 0, o);
        tick(1, 0, o);
        chk("tmsrst_tlr", 64'(tlr), 64'h1);
        tick(0, 0, o);
        scan_dr(32, 64'h0, -1, 1'b0, dout, ok);
        chk("tmsrst_idcode", dout & 64'hFFFFFFFF, 64'h1);

        // trst mid-shift: immediate abort, no update pulse, outputs cleared
        scan_ir(5'h12, irout);
        tick(1, 0, o); tick(0, 0, o); tick(0, 0, o);
        repeat (5) tick(0, 1, o);
        trst_n = 1'b0;
        #1;
        chk("trst_tlr", 64'(tlr), 64'h1);
        chk("trst_outputs", {user_upd, dmi_rst, dmi_hrst, td_o, tdo_oe, sh_dr}, 64'h0);
        chk("trst_user_data", 64'(user_data), 64'h0);
        @(posedge tck); @(negedge tck); #1;
        trst_n = 1'b1;
        tick(1, 0, o);
        chk("trst_no_pulse", 64'(user_upd), 64'h0);
        tick(0, 0, o);
        exp_user_data = '0;
        run_vec('h01, 32, 64'h0, -1, 1'b1, 64'h1, 3'b000, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
